// File: rtl/fold_accumulator.sv
// fold_accumulator: folding histogram. Each accepted hit increments a per-bin
// counter in RAM through a 2-stage read-modify-write pipe with same-bin
// forwarding. Supports an epoch clear sweep and a valid/ready profile dump.
// Optional peak tracking is built when FOLD_PEAK_TRACK_EN is defined.
module fold_accumulator #(
  parameter int NBINS = 1024,
  parameter int BIN_W = 10,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_valid,
  input  logic [BIN_W-1:0] hit_bin,
  input  logic             clear_req,
  input  logic             dump_req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_bin,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] total_hits,
  output logic [15:0]      drop_cnt,
  output logic [BIN_W-1:0] peak_bin,
  output logic [CNT_W-1:0] peak_count
);
  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DUMP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BIN_W:0]   DUMP_END = (BIN_W+1)'(NBINS);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBINS-1);

  state_t           state, target;
  logic [CNT_W-1:0] mem [NBINS];
  logic [BIN_W-1:0] clr_addr;
  logic [BIN_W:0]   dump_addr;
  logic             s0_vld;
  logic [BIN_W-1:0] s0_bin;
  logic [CNT_W-1:0] rd_q;
  logic             fwd_vld;
  logic [BIN_W-1:0] fwd_bin;
  logic [CNT_W-1:0] fwd_val;
  logic [CNT_W-1:0] old_cnt, new_cnt;
  logic             accept, dump_load, clr_entry;

  assign accept    = (state == ACCUM) && hit_valid;
  // The write issued one cycle earlier is not yet visible to the RAM read.
  assign old_cnt   = (fwd_vld && fwd_bin == s0_bin) ? fwd_val : rd_q;
  assign new_cnt   = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + 1'b1;
  assign dump_load = (state == DUMP) && (!out_valid || out_ready);
  assign clr_entry = (state == DRAIN) && !s0_vld && (target == CLEAR);
  assign busy      = (state != ACCUM);

  // RAM: one write port (clear sweep or S1), synchronous read for S0.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_addr] <= '0;
    else if (s0_vld)    mem[s0_bin]   <= new_cnt;
    rd_q <= mem[hit_bin];
  end

  // Increment pipeline S0 -> S1 and forwarding register for the last write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld  <= 1'b0;
      s0_bin  <= '0;
      fwd_vld <= 1'b0;
      fwd_bin <= '0;
      fwd_val <= '0;
    end else begin
      s0_vld  <= accept;
      if (accept) s0_bin <= hit_bin;
      fwd_vld <= s0_vld;
      fwd_bin <= s0_bin;
      fwd_val <= new_cnt;
    end
  end

  // Saturating hit and drop statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_hits <= '0;
      drop_cnt   <= '0;
    end else begin
      if (clr_entry)                          total_hits <= '0;
      else if (s0_vld && total_hits != CNT_MAX) total_hits <= total_hits + 1'b1;
      if (hit_valid && state != ACCUM && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef FOLD_PEAK_TRACK_EN
  // Peak tracker: strict compare keeps the first bin to reach a value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_bin   <= '0;
      peak_count <= '0;
    end else if (clr_entry) begin
      peak_bin   <= '0;
      peak_count <= '0;
    end else if (s0_vld && new_cnt > peak_count) begin
      peak_bin   <= s0_bin;
      peak_count <= new_cnt;
    end
  end
`else
  assign peak_bin   = '0;
  assign peak_count = '0;
`endif

  // Control FSM: clear sweep, accumulate, drain S1, prefetching dump stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      target    <= CLEAR;
      clr_addr  <= '0;
      dump_addr <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_BIN) state <= ACCUM;
        end
        ACCUM: begin
          if (clear_req) begin
            target <= CLEAR;
            state  <= DRAIN;
          end else if (dump_req) begin
            target <= DUMP;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s0_vld) begin
            state     <= target;
            clr_addr  <= '0;
            dump_addr <= '0;
            out_valid <= 1'b0;
          end
        end
        DUMP: begin
          if (dump_load) begin
            if (dump_addr == DUMP_END) begin
              out_valid <= 1'b0;
              state     <= ACCUM;
            end else begin
              out_valid <= 1'b1;
              out_bin   <= dump_addr[BIN_W-1:0];
              out_count <= mem[dump_addr[BIN_W-1:0]];
              dump_addr <= dump_addr + 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
